// File: rtl/dptr_pkg.sv
// Shared constants for the single-cycle R-type slice: opcodes, funct codes,
// ALU operation enum, register preload values and the built-in ROM program.
package dptr_pkg;

   localparam int ROM_WORDS_DEF = 64;
   localparam int NUM_REGS      = 32;
   localparam int PROG_LEN      = 7;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;

   typedef enum logic [2:0] {
      ALU_NONE,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_NOR
   } alu_op_e;

   localparam logic [31:0] PRELOAD_R5  = 32'd20;
   localparam logic [31:0] PRELOAD_R9  = 32'd100;
   localparam logic [31:0] PRELOAD_R15 = 32'd999;

   // sub $20,$15,$9 / add $15,$5,$15 / and $1,$9,$5 / or $2,$9,$5 /
   // slt $3,$5,$9 / sub $4,$5,$9 / add $0,$9,$9
   localparam logic [31:0] PROG_W0 = 32'h01E9A022;
   localparam logic [31:0] PROG_W1 = 32'h00AF7820;
   localparam logic [31:0] PROG_W2 = 32'h01250824;
   localparam logic [31:0] PROG_W3 = 32'h01251025;
   localparam logic [31:0] PROG_W4 = 32'h00A9182A;
   localparam logic [31:0] PROG_W5 = 32'h00A92022;
   localparam logic [31:0] PROG_W6 = 32'h01290020;

   function automatic logic [31:0] prog_word(input logic [31:0] idx);
      case (idx)
         32'd0:   return PROG_W0;
         32'd1:   return PROG_W1;
         32'd2:   return PROG_W2;
         32'd3:   return PROG_W3;
         32'd4:   return PROG_W4;
         32'd5:   return PROG_W5;
         32'd6:   return PROG_W6;
         default: return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] preload_word(input int idx);
      case (idx)
         5:       return PRELOAD_R5;
         9:       return PRELOAD_R9;
         15:      return PRELOAD_R15;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/fetch.sv
// Fetch stage: byte-addressed PC with wrap at the end of the ROM, and the
// read-only program store indexed by the PC word address.
module fetch
   import dptr_pkg::*;
#(
   parameter int ROM_WORDS = ROM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic [31:0] instr
);

   localparam int AW = $clog2(ROM_WORDS);

   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic [AW-1:0] word_idx;

   assign word_idx = pc_q[AW+1:2];

   // The last ROM word wraps back to address 0 rather than running off the end.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (word_idx == {AW{1'b1}}) begin
         pc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_comb begin
      instr = prog_word(32'(word_idx));
   end

   assign pc = pc_q;

endmodule

// File: rtl/dptr_fetch.sv
// Single-cycle MIPS R-type slice: fetch, register file, ALU and writeback.
// Define DPTR_EXT_ALU_EN to add the slt and nor operations.
module dptr_fetch
   import dptr_pkg::*;
#(
   parameter int ROM_WORDS = ROM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [31:0] alu_result,
   output logic [31:0] r20_out
);

   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] regs_d [NUM_REGS];

   logic [5:0]  op;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [4:0]  rd_addr;
   logic [5:0]  funct;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   alu_op_e     alu_op;
   logic        wr_en;

   fetch #(
      .ROM_WORDS (ROM_WORDS)
   ) u_fetch (
      .clk   (clk),
      .rst   (rst),
      .pc    (pc),
      .instr (instr)
   );

   assign op      = instr[31:26];
   assign rs_addr = instr[25:21];
   assign rt_addr = instr[20:16];
   assign rd_addr = instr[15:11];
   assign funct   = instr[5:0];

   assign rs_val = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
   assign rt_val = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];

   always_comb begin
      alu_op = ALU_NONE;
      if (op == OP_RTYPE) begin
         case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
`ifdef DPTR_EXT_ALU_EN
            FUNCT_SLT: alu_op = ALU_SLT;
            FUNCT_NOR: alu_op = ALU_NOR;
`endif
            default:   alu_op = ALU_NONE;
         endcase
      end
   end

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         ALU_ADD: alu_result = rs_val + rt_val;
         ALU_SUB: alu_result = rs_val - rt_val;
         ALU_AND: alu_result = rs_val & rt_val;
         ALU_OR:  alu_result = rs_val | rt_val;
         ALU_SLT: alu_result = {31'd0, ($signed(rs_val) < $signed(rt_val))};
         ALU_NOR: alu_result = ~(rs_val | rt_val);
         default: alu_result = 32'd0;
      endcase
   end

   // Unsupported instructions and writes to $0 leave the register file untouched.
   always_comb begin
      wr_en  = (alu_op != ALU_NONE) && (rd_addr != 5'd0);
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[rd_addr] = alu_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= preload_word(i);
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign r20_out = regs_q[20];

endmodule

// File: tb/tb_dptr_fetch.sv
// Self-checking bench for dptr_fetch against an instruction-level model of
// the program, register file and PC.
module tb_dptr_fetch;

   localparam int ROM_WORDS = 64;
`ifdef DPTR_EXT_ALU_EN
   localparam bit EXT = 1'b1;
`else
   localparam bit EXT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] alu_result;
   logic [31:0] r20_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_rom  [ROM_WORDS];
   logic [31:0] m_pc;

   dptr_fetch #(
      .ROM_WORDS (ROM_WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .instr      (instr),
      .alu_result (alu_result),
      .r20_out    (r20_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input int rs, input int rt, input int rd, input int fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction

   task automatic build_rom();
      for (int i = 0; i < ROM_WORDS; i++) m_rom[i] = 32'd0;
      m_rom[0] = enc(15, 9, 20, 'h22);
      m_rom[1] = enc(5, 15, 15, 'h20);
      m_rom[2] = enc(9, 5, 1, 'h24);
      m_rom[3] = enc(9, 5, 2, 'h25);
      m_rom[4] = enc(5, 9, 3, 'h2A);
      m_rom[5] = enc(5, 9, 4, 'h22);
      m_rom[6] = enc(9, 9, 0, 'h20);
   endtask

   task automatic model_reset();
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_regs[5]  = 32'd20;
      m_regs[9]  = 32'd100;
      m_regs[15] = 32'd999;
   endtask

   // Returns {write_valid, result} for one instruction on the current model state.
   function automatic logic [32:0] model_exec(input logic [31:0] ins);
      logic [31:0] a;
      logic [31:0] b;
      a = m_regs[ins[25:21]];
      b = m_regs[ins[20:16]];
      if (ins[31:26] != 6'd0) return 33'd0;
      case (ins[5:0])
         6'h20: return {1'b1, a + b};
         6'h22: return {1'b1, a - b};
         6'h24: return {1'b1, a & b};
         6'h25: return {1'b1, a | b};
         6'h2A: return EXT ? {1'b1, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)} : 33'd0;
         6'h27: return EXT ? {1'b1, ~(a | b)} : 33'd0;
         default: return 33'd0;
      endcase
   endfunction

   function automatic logic [31:0] model_instr();
      return m_rom[(m_pc / 4) % ROM_WORDS];
   endfunction

   // Advances the model alongside the DUT across one rising edge, then parks on the falling edge.
   task automatic step();
      logic [32:0] r;
      logic [31:0] ins;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         ins = model_instr();
         r   = model_exec(ins);
         if (r[32] && ins[15:11] != 5'd0) m_regs[ins[15:11]] = r[31:0];
         m_pc = (m_pc + 32'd4) % (4 * ROM_WORDS);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_tests++;
      if (pc !== 32'd0) begin
         n_fail++; $display("[TB] FAIL reset_pc got %0d want 0", pc);
      end
      n_tests++;
      if (r20_out !== 32'd0) begin
         n_fail++; $display("[TB] FAIL reset_r20 got %0d want 0", r20_out);
      end
      n_tests++;
      if (alu_result !== 32'd899) begin
         n_fail++; $display("[TB] FAIL reset_alu got %0d want 899", alu_result);
      end
      n_tests++;
      if (instr !== 32'h01E9A022) begin
         n_fail++; $display("[TB] FAIL reset_instr got %h want 01e9a022", instr);
      end
      n_tests++;
      if (dut.regs_q[15] !== 32'd999) begin
         n_fail++; $display("[TB] FAIL reset_r15 got %0d want 999", dut.regs_q[15]);
      end
   endtask

   task automatic test_program();
      logic [31:0] want3;
      want3 = EXT ? 32'd1 : 32'd0;
      rst = 1'b0;
      step();
      n_tests++;
      if (r20_out !== 32'd899 || pc !== 32'd4) begin
         n_fail++; $display("[TB] FAIL edge1 got r20=%0d pc=%0d want r20=899 pc=4", r20_out, pc);
      end
      step();
      n_tests++;
      if (dut.regs_q[15] !== 32'd1019 || pc !== 32'd8) begin
         n_fail++; $display("[TB] FAIL edge2 got r15=%0d pc=%0d want r15=1019 pc=8", dut.regs_q[15], pc);
      end
      repeat (5) step();
      n_tests++;
      if (dut.regs_q[1] !== 32'd4 || dut.regs_q[2] !== 32'd116) begin
         n_fail++; $display("[TB] FAIL and_or got r1=%0d r2=%0d want r1=4 r2=116", dut.regs_q[1], dut.regs_q[2]);
      end
      n_tests++;
      if (dut.regs_q[3] !== want3) begin
         n_fail++; $display("[TB] FAIL slt got r3=%0d want %0d", dut.regs_q[3], want3);
      end
      n_tests++;
      if (dut.regs_q[4] !== 32'hFFFF_FFB0 || dut.regs_q[0] !== 32'd0) begin
         n_fail++; $display("[TB] FAIL sub_r0 got r4=%h r0=%h want r4=ffffffb0 r0=0", dut.regs_q[4], dut.regs_q[0]);
      end
      n_tests++;
      if (pc !== 32'd28 || alu_result !== 32'd0 || instr !== 32'd0) begin
         n_fail++; $display("[TB] FAIL nop_entry got pc=%0d alu=%0d instr=%h want 28 0 0", pc, alu_result, instr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] prev_pc;
      logic [31:0] prev_r20;
      for (int i = 0; i < 58; i++) begin
         prev_pc  = pc;
         prev_r20 = r20_out;
         step();
         if (m_pc >= 32'd28) begin
            n_tests++;
            if (pc !== prev_pc + 32'd4 || alu_result !== 32'd0 || r20_out !== prev_r20) begin
               n_fail++;
               $display("[TB] FAIL nop_region got pc=%0d alu=%0d r20=%0d want pc=%0d alu=0 r20=%0d",
                        pc, alu_result, r20_out, prev_pc + 32'd4, prev_r20);
            end
         end
      end
      n_tests++;
      if (pc !== 32'd4 || r20_out !== 32'd919) begin
         n_fail++; $display("[TB] FAIL wrap got pc=%0d r20=%0d want pc=4 r20=919", pc, r20_out);
      end
   endtask

   task automatic test_mid_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      n_tests++;
      if (pc !== 32'd12) begin
         n_fail++; $display("[TB] FAIL midrst_setup got pc=%0d want 12", pc);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if (pc !== 32'd0 || r20_out !== 32'd0 || alu_result !== 32'd899) begin
         n_fail++; $display("[TB] FAIL midrst_out got pc=%0d r20=%0d alu=%0d want 0 0 899", pc, r20_out, alu_result);
      end
      n_tests++;
      if (dut.regs_q[1] !== 32'd0 || dut.regs_q[2] !== 32'd0 || dut.regs_q[15] !== 32'd999) begin
         n_fail++; $display("[TB] FAIL midrst_regs got r1=%0d r2=%0d r15=%0d want 0 0 999",
                            dut.regs_q[1], dut.regs_q[2], dut.regs_q[15]);
      end
   endtask

   task automatic test_random();
      logic [31:0] want_alu;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 24) == 0);
         step();
         want_alu = model_exec(model_instr()) >> 0;
         n_tests++;
         if (pc !== m_pc || instr !== model_instr()) begin
            n_fail++; $display("[TB] FAIL rand_fetch cyc %0d got pc=%0d instr=%h want pc=%0d instr=%h",
                               i, pc, instr, m_pc, model_instr());
         end
         n_tests++;
         if (alu_result !== want_alu) begin
            n_fail++; $display("[TB] FAIL rand_alu cyc %0d got %h want %h", i, alu_result, want_alu);
         end
         n_tests++;
         if (r20_out !== m_regs[20]) begin
            n_fail++; $display("[TB] FAIL rand_r20 cyc %0d got %0d want %0d", i, r20_out, m_regs[20]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      build_rom();
      model_reset();
      test_reset();
      test_program();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
